// File: rtl/piece_controller.sv
// Falling-piece controller for a block-stacking game.
// Holds the active piece (shape, rotation, origin), produces its four cells
// and the four cells of every candidate move, and sequences spawn, fall,
// lock and game-over around the board's legality answers.

package piece_controller_pkg;
   typedef enum logic [2:0] {
      EMPTY   = 3'd0,
      I_BLOCK = 3'd1,
      O_BLOCK = 3'd2,
      T_BLOCK = 3'd3,
      S_BLOCK = 3'd4,
      Z_BLOCK = 3'd5,
      J_BLOCK = 3'd6,
      L_BLOCK = 3'd7
   } block_color;
endpackage

module piece_controller
   import piece_controller_pkg::*;
#(
   parameter int          GRAVITY_FRAMES = 30,
   parameter logic [4:0]  SPAWN_X        = 5'd3
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_clk_rising_edge,
   input  logic        key_left,
   input  logic        key_right,
   input  logic        key_down,
   input  logic        key_rot_l,
   input  logic        key_rot_r,
   input  logic [4:0]  can_move,
   input  logic        BOARD_BUSY,
   output logic [19:0] x_block,
   output logic [19:0] y_block,
   output logic [19:0] save_xblock,
   output logic [19:0] save_yblock,
   output logic [19:0] x_move_left,
   output logic [19:0] y_move_left,
   output logic [19:0] x_move_right,
   output logic [19:0] y_move_right,
   output logic [19:0] x_move_down,
   output logic [19:0] y_move_down,
   output logic [19:0] x_rotate_left,
   output logic [19:0] y_rotate_left,
   output logic [19:0] x_rotate_right,
   output logic [19:0] y_rotate_right,
   output logic        get_new_block,
   output block_color  block,
   output logic        game_over
);

   localparam int CW = (GRAVITY_FRAMES > 1) ? $clog2(GRAVITY_FRAMES) : 1;

   typedef enum logic [2:0] {SPAWN, PLACE, WAIT, FALL, LOCK, OVER} state_t;

   state_t          state;
   logic [2:0]      lfsr;
   logic [2:0]      piece;
   logic [1:0]      rot;
   logic [4:0]      ox;
   logic [4:0]      oy;
   logic [CW-1:0]   grav_cnt;
   logic [4:0]      key_prev;
   logic [4:0]      pend;
   logic [4:0]      keys;
   logic [4:0]      rises;
   logic            tick_taken;
   logic            down_due;
   logic [39:0]     cur_cells;
   logic [39:0]     left_cells;
   logic [39:0]     right_cells;
   logic [39:0]     down_cells;
   logic [39:0]     rotl_cells;
   logic [39:0]     rotr_cells;

   // Returns {x fields, y fields} for a piece: rot-0 offsets rotated
   // clockwise rot times inside an N x N box, then added to the origin
   // with 5-bit wraparound. The O piece never rotates.
   function automatic logic [39:0] piece_cells(input logic [2:0] p,
                                               input logic [1:0] r,
                                               input logic [4:0] x0,
                                               input logic [4:0] y0);
      logic [15:0] offs;
      logic [1:0]  dx;
      logic [1:0]  dy;
      logic [1:0]  tmp;
      logic [1:0]  n1;
      logic [1:0]  steps;
      logic [19:0] xs;
      logic [19:0] ys;
      case (p)
         3'd1:    offs = {2'd0,2'd1, 2'd1,2'd1, 2'd2,2'd1, 2'd3,2'd1};
         3'd2:    offs = {2'd1,2'd0, 2'd2,2'd0, 2'd1,2'd1, 2'd2,2'd1};
         3'd3:    offs = {2'd1,2'd0, 2'd0,2'd1, 2'd1,2'd1, 2'd2,2'd1};
         3'd4:    offs = {2'd1,2'd0, 2'd2,2'd0, 2'd0,2'd1, 2'd1,2'd1};
         3'd5:    offs = {2'd0,2'd0, 2'd1,2'd0, 2'd1,2'd1, 2'd2,2'd1};
         3'd6:    offs = {2'd0,2'd0, 2'd0,2'd1, 2'd1,2'd1, 2'd2,2'd1};
         3'd7:    offs = {2'd2,2'd0, 2'd0,2'd1, 2'd1,2'd1, 2'd2,2'd1};
         default: offs = 16'd0;
      endcase
      n1    = (p == 3'd1) ? 2'd3 : 2'd2;
      steps = (p == 3'd2) ? 2'd0 : r;
      xs    = 20'd0;
      ys    = 20'd0;
      for (int i = 0; i < 4; i++) begin
         dx = offs[15 - 4*i -: 2];
         dy = offs[13 - 4*i -: 2];
         for (int s = 0; s < 3; s++) begin
            if (2'(s) < steps) begin
               tmp = dx;
               dx  = n1 - dy;
               dy  = tmp;
            end
         end
         xs[19 - 5*i -: 5] = x0 + {3'b000, dx};
         ys[19 - 5*i -: 5] = y0 + {3'b000, dy};
      end
      return {xs, ys};
   endfunction

   assign cur_cells   = piece_cells(piece, rot,         ox,         oy);
   assign left_cells  = piece_cells(piece, rot,         ox - 5'd1,  oy);
   assign right_cells = piece_cells(piece, rot,         ox + 5'd1,  oy);
   assign down_cells  = piece_cells(piece, rot,         ox,         oy + 5'd1);
   assign rotl_cells  = piece_cells(piece, rot - 2'd1,  ox,         oy);
   assign rotr_cells  = piece_cells(piece, rot + 2'd1,  ox,         oy);

   assign {x_block,        y_block}        = cur_cells;
   assign {x_move_left,    y_move_left}    = left_cells;
   assign {x_move_right,   y_move_right}   = right_cells;
   assign {x_move_down,    y_move_down}    = down_cells;
   assign {x_rotate_left,  y_rotate_left}  = rotl_cells;
   assign {x_rotate_right, y_rotate_right} = rotr_cells;

   assign block = block_color'(piece);

   // Key vector ordered by action priority: rot_r, rot_l, left, right, down.
   assign keys       = {key_rot_r, key_rot_l, key_left, key_right, key_down};
   assign rises      = keys & ~key_prev;
   assign tick_taken = (state == FALL) && frame_clk_rising_edge && !BOARD_BUSY;
   assign down_due   = (grav_cnt == CW'(GRAVITY_FRAMES - 1)) || pend[0];

   // Free-running 3-bit LFSR (x^3+x^2+1) that picks the next piece shape.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) lfsr <= 3'b001;
      else       lfsr <= {lfsr[1:0], lfsr[2] ^ lfsr[1]};
   end

   // Remembers the previous cell set so the board can erase the old piece.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         save_xblock <= 20'd0;
         save_yblock <= 20'd0;
      end else begin
         save_xblock <= x_block;
         save_yblock <= y_block;
      end
   end

   // Latches key presses until the next frame tick the falling piece consumes.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         key_prev <= 5'd0;
         pend     <= 5'd0;
      end else if (state != OVER) begin
         key_prev <= keys;
         pend     <= (tick_taken ? 5'd0 : pend) | rises;
      end
   end

   // Piece life cycle: spawn, announce, wait for the board, fall, lock.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state         <= SPAWN;
         piece         <= 3'd0;
         rot           <= 2'd0;
         ox            <= 5'd0;
         oy            <= 5'd0;
         grav_cnt      <= '0;
         get_new_block <= 1'b0;
         game_over     <= 1'b0;
      end else begin
         get_new_block <= 1'b0;
         case (state)
            SPAWN: begin
               piece         <= lfsr;
               rot           <= 2'd0;
               ox            <= SPAWN_X;
               oy            <= 5'd0;
               get_new_block <= 1'b1;
               state         <= PLACE;
            end
            PLACE: state <= WAIT;
            WAIT: begin
               if (!BOARD_BUSY) state <= FALL;
            end
            FALL: begin
               if (tick_taken) begin
                  grav_cnt <= down_due ? '0 : grav_cnt + CW'(1);
                  if (pend[4] && can_move[2])      rot <= rot + 2'd1;
                  else if (pend[3] && can_move[1]) rot <= rot - 2'd1;
                  else if (pend[2] && can_move[4]) ox  <= ox - 5'd1;
                  else if (pend[1] && can_move[3]) ox  <= ox + 5'd1;
                  else if (down_due) begin
                     if (can_move[0]) oy    <= oy + 5'd1;
                     else             state <= LOCK;
                  end
               end
            end
            LOCK: begin
               if (oy == 5'd0) begin
                  state     <= OVER;
                  game_over <= 1'b1;
               end else begin
                  state <= SPAWN;
               end
            end
            OVER:    state <= OVER;
            default: state <= SPAWN;
         endcase
      end
   end

endmodule

// File: tb/tb_piece_controller.sv
// Directed bench for piece_controller: spawn, lateral moves at the left
// wall, rotation priority, gravity, lock/respawn with board busy, game over
// and asynchronous reset.

module tb_piece_controller;
   import piece_controller_pkg::*;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        frame_clk_rising_edge = 1'b0;
   logic        key_left = 1'b0, key_right = 1'b0, key_down = 1'b0;
   logic        key_rot_l = 1'b0, key_rot_r = 1'b0;
   logic [4:0]  can_move = 5'b11111;
   logic        BOARD_BUSY = 1'b0;
   logic [19:0] x_block, y_block, save_xblock, save_yblock;
   logic [19:0] x_move_left, y_move_left, x_move_right, y_move_right;
   logic [19:0] x_move_down, y_move_down, x_rotate_left, y_rotate_left;
   logic [19:0] x_rotate_right, y_rotate_right;
   logic        get_new_block, game_over;
   block_color  block;

   int          tests_run = 0;
   int          tests_failed = 0;
   logic [2:0]  lfsr_model;

   piece_controller #(.GRAVITY_FRAMES(30), .SPAWN_X(5'd3)) dut (
      .Clk(Clk), .Reset(Reset), .frame_clk_rising_edge(frame_clk_rising_edge),
      .key_left(key_left), .key_right(key_right), .key_down(key_down),
      .key_rot_l(key_rot_l), .key_rot_r(key_rot_r), .can_move(can_move),
      .BOARD_BUSY(BOARD_BUSY), .x_block(x_block), .y_block(y_block),
      .save_xblock(save_xblock), .save_yblock(save_yblock),
      .x_move_left(x_move_left), .y_move_left(y_move_left),
      .x_move_right(x_move_right), .y_move_right(y_move_right),
      .x_move_down(x_move_down), .y_move_down(y_move_down),
      .x_rotate_left(x_rotate_left), .y_rotate_left(y_rotate_left),
      .x_rotate_right(x_rotate_right), .y_rotate_right(y_rotate_right),
      .get_new_block(get_new_block), .block(block), .game_over(game_over)
   );

   always #5 Clk = ~Clk;

   // Reference shape-selection sequence, used only to time lock events so a
   // chosen piece is spawned.
   always @(posedge Clk or posedge Reset) begin
      if (Reset) lfsr_model <= 3'b001;
      else       lfsr_model <= {lfsr_model[1:0], lfsr_model[2] ^ lfsr_model[1]};
   end

   function automatic logic [19:0] f4(input logic [4:0] a, input logic [4:0] b,
                                      input logic [4:0] c, input logic [4:0] d);
      return {a, b, c, d};
   endfunction

   // mask order: rot_r, rot_l, left, right, down
   task automatic press(input logic [4:0] m);
      @(negedge Clk);
      {key_rot_r, key_rot_l, key_left, key_right, key_down} = m;
      @(negedge Clk);
      {key_rot_r, key_rot_l, key_left, key_right, key_down} = 5'b00000;
   endtask

   task automatic tick();
      @(negedge Clk);
      frame_clk_rising_edge = 1'b1;
      @(negedge Clk);
      frame_clk_rising_edge = 1'b0;
   endtask

   // Forces a down attempt against a blocked board at an edge where the
   // shape LFSR holds lock_lfsr, so the respawn loads a known shape.
   task automatic lock_and_spawn(input block_color exp_piece, input logic [2:0] lock_lfsr,
                                 input logic [19:0] exp_x, input logic [19:0] exp_y,
                                 input string name);
      can_move = 5'b11110;
      press(5'b00001);
      for (int i = 0; i < 16 && lfsr_model !== lock_lfsr; i++) @(negedge Clk);
      tests_run++;
      if (lfsr_model !== lock_lfsr) begin
         tests_failed++;
         $display("[TB] FAIL %s_sync: lfsr %b never reached %b", name, lfsr_model, lock_lfsr);
      end
      frame_clk_rising_edge = 1'b1;
      @(negedge Clk);
      frame_clk_rising_edge = 1'b0;
      tests_run++;
      if (get_new_block !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL %s_lock_pulse: get_new_block=%b expected 0", name, get_new_block);
      end
      @(negedge Clk);
      tests_run++;
      if (get_new_block !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL %s_spawn_pulse: get_new_block=%b expected 0", name, get_new_block);
      end
      @(negedge Clk);
      tests_run++;
      if (get_new_block !== 1'b1 || block !== exp_piece) begin
         tests_failed++;
         $display("[TB] FAIL %s_place: get_new_block=%b block=%0d expected 1/%0d",
                  name, get_new_block, block, exp_piece);
      end
      tests_run++;
      if (x_block !== exp_x || y_block !== exp_y) begin
         tests_failed++;
         $display("[TB] FAIL %s_cells: x=%h y=%h expected x=%h y=%h", name, x_block, y_block, exp_x, exp_y);
      end
      @(negedge Clk);
      tests_run++;
      if (get_new_block !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL %s_pulse_width: get_new_block=%b expected 0", name, get_new_block);
      end
      can_move = 5'b11111;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge Clk);
      tests_run++;
      if (get_new_block !== 1'b0 || game_over !== 1'b0 || block !== EMPTY) begin
         tests_failed++;
         $display("[TB] FAIL reset_flags: gnb=%b over=%b block=%0d expected 0/0/0", get_new_block, game_over, block);
      end
      tests_run++;
      if (save_xblock !== 20'd0 || save_yblock !== 20'd0) begin
         tests_failed++;
         $display("[TB] FAIL reset_save: x=%h y=%h expected 0/0", save_xblock, save_yblock);
      end
      Reset = 1'b0;
   endtask

   task automatic test_spawn();
      @(negedge Clk);
      tests_run++;
      if (get_new_block !== 1'b1 || block !== I_BLOCK) begin
         tests_failed++;
         $display("[TB] FAIL spawn_pulse: gnb=%b block=%0d expected 1/%0d", get_new_block, block, I_BLOCK);
      end
      tests_run++;
      if (x_block !== f4(3, 4, 5, 6) || y_block !== f4(1, 1, 1, 1)) begin
         tests_failed++;
         $display("[TB] FAIL spawn_cells: x=%h y=%h expected %h %h", x_block, y_block, f4(3, 4, 5, 6), f4(1, 1, 1, 1));
      end
      @(negedge Clk);
      tests_run++;
      if (get_new_block !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL spawn_pulse_width: gnb=%b expected 0", get_new_block);
      end
   endtask

   task automatic test_left_wall();
      logic [4:0] field;
      repeat (3) begin
         press(5'b00100);
         tick();
      end
      tests_run++;
      if (x_block !== f4(0, 1, 2, 3)) begin
         tests_failed++;
         $display("[TB] FAIL left_moves: x=%h expected %h", x_block, f4(0, 1, 2, 3));
      end
      field = x_move_left[19:15];
      tests_run++;
      if (field !== 5'd31 || x_move_left !== f4(31, 0, 1, 2)) begin
         tests_failed++;
         $display("[TB] FAIL left_wrap: x_move_left=%h expected %h", x_move_left, f4(31, 0, 1, 2));
      end
      tests_run++;
      if (x_move_right !== f4(1, 2, 3, 4) || y_move_down !== f4(2, 2, 2, 2)) begin
         tests_failed++;
         $display("[TB] FAIL cand_right_down: xr=%h yd=%h expected %h %h", x_move_right, y_move_down, f4(1, 2, 3, 4), f4(2, 2, 2, 2));
      end
      tests_run++;
      if (x_rotate_right !== f4(2, 2, 2, 2) || y_rotate_right !== f4(0, 1, 2, 3)) begin
         tests_failed++;
         $display("[TB] FAIL cand_rot_r: x=%h y=%h expected %h %h", x_rotate_right, y_rotate_right, f4(2, 2, 2, 2), f4(0, 1, 2, 3));
      end
      tests_run++;
      if (x_rotate_left !== f4(1, 1, 1, 1) || y_rotate_left !== f4(3, 2, 1, 0)) begin
         tests_failed++;
         $display("[TB] FAIL cand_rot_l: x=%h y=%h expected %h %h", x_rotate_left, y_rotate_left, f4(1, 1, 1, 1), f4(3, 2, 1, 0));
      end
      can_move = 5'b01111;
      press(5'b00100);
      tick();
      can_move = 5'b11111;
      tests_run++;
      if (x_block !== f4(0, 1, 2, 3)) begin
         tests_failed++;
         $display("[TB] FAIL left_blocked: x=%h expected %h", x_block, f4(0, 1, 2, 3));
      end
   endtask

   task automatic test_rotate_priority();
      press(5'b10100);
      tick();
      tests_run++;
      if (x_block !== f4(2, 2, 2, 2) || y_block !== f4(0, 1, 2, 3)) begin
         tests_failed++;
         $display("[TB] FAIL rot_over_left: x=%h y=%h expected %h %h", x_block, y_block, f4(2, 2, 2, 2), f4(0, 1, 2, 3));
      end
      tick();
      tests_run++;
      if (x_block !== f4(2, 2, 2, 2)) begin
         tests_failed++;
         $display("[TB] FAIL left_discarded: x=%h expected %h", x_block, f4(2, 2, 2, 2));
      end
      press(5'b00001);
      tick();
      tests_run++;
      if (y_block !== f4(1, 2, 3, 4)) begin
         tests_failed++;
         $display("[TB] FAIL key_down: y=%h expected %h", y_block, f4(1, 2, 3, 4));
      end
      lock_and_spawn(T_BLOCK, 3'b010, f4(4, 3, 4, 5), f4(0, 1, 1, 1), "t_spawn");
   endtask

   task automatic test_gravity();
      repeat (29) tick();
      tests_run++;
      if (y_block !== f4(0, 1, 1, 1)) begin
         tests_failed++;
         $display("[TB] FAIL gravity_early: y=%h expected %h", y_block, f4(0, 1, 1, 1));
      end
      tick();
      tests_run++;
      if (y_block !== f4(1, 2, 2, 2) || x_block !== f4(4, 3, 4, 5)) begin
         tests_failed++;
         $display("[TB] FAIL gravity_step: x=%h y=%h expected %h %h", x_block, y_block, f4(4, 3, 4, 5), f4(1, 2, 2, 2));
      end
      tests_run++;
      if (save_yblock !== f4(0, 1, 1, 1)) begin
         tests_failed++;
         $display("[TB] FAIL save_delay: save_y=%h expected %h", save_yblock, f4(0, 1, 1, 1));
      end
   endtask

   task automatic test_lock_busy();
      repeat (4) begin
         press(5'b00001);
         tick();
      end
      tests_run++;
      if (y_block !== f4(5, 6, 6, 6)) begin
         tests_failed++;
         $display("[TB] FAIL down_to_5: y=%h expected %h", y_block, f4(5, 6, 6, 6));
      end
      lock_and_spawn(O_BLOCK, 3'b100, f4(4, 5, 4, 5), f4(0, 0, 1, 1), "o_spawn");
      BOARD_BUSY = 1'b1;
      press(5'b00001);
      tick();
      tick();
      repeat (4) @(negedge Clk);
      tests_run++;
      if (y_block !== f4(0, 0, 1, 1)) begin
         tests_failed++;
         $display("[TB] FAIL busy_hold: y=%h expected %h", y_block, f4(0, 0, 1, 1));
      end
      BOARD_BUSY = 1'b0;
      frame_clk_rising_edge = 1'b1;
      @(negedge Clk);
      frame_clk_rising_edge = 1'b0;
      tests_run++;
      if (y_block !== f4(0, 0, 1, 1)) begin
         tests_failed++;
         $display("[TB] FAIL wait_exit_tick: y=%h expected %h", y_block, f4(0, 0, 1, 1));
      end
      tick();
      tests_run++;
      if (y_block !== f4(1, 1, 2, 2)) begin
         tests_failed++;
         $display("[TB] FAIL after_busy_down: y=%h expected %h", y_block, f4(1, 1, 2, 2));
      end
   endtask

   task automatic test_game_over();
      lock_and_spawn(I_BLOCK, 3'b110, f4(3, 4, 5, 6), f4(1, 1, 1, 1), "i_spawn");
      can_move = 5'b11110;
      press(5'b00001);
      tick();
      tests_run++;
      if (game_over !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL over_early: game_over=%b expected 0", game_over);
      end
      @(negedge Clk);
      tests_run++;
      if (game_over !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL over_set: game_over=%b expected 1", game_over);
      end
      for (int i = 0; i < 12; i++) begin
         @(negedge Clk);
         frame_clk_rising_edge = (i % 3 == 1);
         {key_rot_r, key_rot_l, key_left, key_right, key_down} = (i % 2 == 1) ? 5'b11111 : 5'b00000;
         tests_run++;
         if (get_new_block !== 1'b0 || game_over !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL over_hold_%0d: gnb=%b over=%b expected 0/1", i, get_new_block, game_over);
         end
      end
      frame_clk_rising_edge = 1'b0;
      {key_rot_r, key_rot_l, key_left, key_right, key_down} = 5'b00000;
      can_move = 5'b11111;
      @(negedge Clk);
      tests_run++;
      if (x_block !== f4(3, 4, 5, 6) || y_block !== f4(1, 1, 1, 1)) begin
         tests_failed++;
         $display("[TB] FAIL over_frozen: x=%h y=%h expected %h %h", x_block, y_block, f4(3, 4, 5, 6), f4(1, 1, 1, 1));
      end
      Reset = 1'b1;
      #1;
      tests_run++;
      if (game_over !== 1'b0 || block !== EMPTY || get_new_block !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL over_reset: over=%b block=%0d gnb=%b expected 0/0/0", game_over, block, get_new_block);
      end
      @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      tests_run++;
      if (get_new_block !== 1'b1 || block !== I_BLOCK) begin
         tests_failed++;
         $display("[TB] FAIL respawn_after_over: gnb=%b block=%0d expected 1/%0d", get_new_block, block, I_BLOCK);
      end
   endtask

   task automatic test_reset_midway();
      press(5'b00100);
      tick();
      tests_run++;
      if (x_block !== f4(2, 3, 4, 5)) begin
         tests_failed++;
         $display("[TB] FAIL midway_move: x=%h expected %h", x_block, f4(2, 3, 4, 5));
      end
      @(posedge Clk);
      #2;
      Reset = 1'b1;
      #1;
      tests_run++;
      if (block !== EMPTY || get_new_block !== 1'b0 || save_xblock !== 20'd0) begin
         tests_failed++;
         $display("[TB] FAIL midway_reset: block=%0d gnb=%b save_x=%h expected 0/0/0", block, get_new_block, save_xblock);
      end
      @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      tests_run++;
      if (get_new_block !== 1'b1 || x_block !== f4(3, 4, 5, 6)) begin
         tests_failed++;
         $display("[TB] FAIL midway_respawn: gnb=%b x=%h expected 1 %h", get_new_block, x_block, f4(3, 4, 5, 6));
      end
   endtask

   initial begin
      test_reset();
      test_spawn();
      test_left_wall();
      test_rotate_priority();
      test_gravity();
      test_lock_busy();
      test_game_over();
      test_reset_midway();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: run did not reach the summary");
      $fatal(1);
   end

endmodule
